saw_note_scheduler: RTL and testbench
=====================================

# saw_note_scheduler

Note-sequencing controller for the 8-bit sawtooth voice. Buffers queued notes (pitch period, duration) in a small FIFO and plays them back-to-back by driving a per-step enable and a synchronous clear into the sawtooth counter. It also provides mute and status to the output mixer. The block sits between the note source (host/ROM player) and the sawtooth datapath, and owns all timing of that datapath.

## Interface
- DEPTH, 8: note FIFO entries (power of two, ≥2)
- PER_W, 16: width of note period field
- DUR_W, 8: width of note duration field
- REST_PER, 64: clocks per step used for timing rests

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- note_valid  in  1  host offers a note
- note_ready  out  1  FIFO not full and no flush this cycle
- note_period  in  PER_W  clocks per sawtooth step; 0 = rest
- note_dur  in  DUR_W  note length in full sawtooth cycles (256 steps); 0 treated as 1
- run  in  1  level; 0 pauses playback
- flush  in  1  pulse; empty FIFO, abort current note
- saw_step  out  1  one-cycle enable: advance sawtooth count by 1
- saw_clear  out  1  one-cycle: force sawtooth count to 0
- mute  out  1  mixer must silence output
- busy  out  1  state ≠ IDLE
- note_done  out  1  one-cycle pulse at end of each note/rest
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset values: saw_step=0, saw_clear=0, mute=1, busy=0, note_done=0, fifo_level=0, note_ready=1; state IDLE; all counters 0.
- Write accepted when note_valid && note_ready. note_ready = !full && !flush.
- States:
  - IDLE: mute=1. Moves to LOAD when run=1 and FIFO is non-empty.
  - LOAD: lasts 1 cycle. Pops the head entry, pulses saw_clear, and loads the counters:
    - period counter = period−1, or REST_PER−1 for a rest
    - step counter = 0
    - cycle counter = max(dur,1)−1
    - Goes to PLAY.
  - PLAY: mute=0 for a note, 1 for a rest.
    - Period counter decrements each cycle while run=1.
    - At 0: reload, and increment the 8-bit step counter. saw_step=1 for a note; no saw_step for a rest.
    - When the step counter wraps 255→0: if cycle counter = 0, pulse note_done and exit PLAY; otherwise decrement the cycle counter.
    - On exit: go to LOAD if run=1 and FIFO is non-empty, else IDLE.
- run=0 in PLAY: all counters hold, no saw_step, state and mute unchanged. run=0 in IDLE: stays IDLE.
- flush (any state): FIFO emptied, state → IDLE next cycle, saw_clear pulsed, mute=1, no note_done.
- Period=1: saw_step every PLAY cycle.
- Step count per note = 256 × max(dur,1). Wrap of the sawtooth coincides with the step counter wrap.

## Timing
- LOAD at cycle T (saw_clear=1 at T) → first saw_step at T+period; subsequent steps every period cycles.
- note_done is asserted in the same cycle as the final saw_step (rest: the final step tick). The next LOAD follows on the next cycle, giving a 1-cycle gap and no saw_step in LOAD.
- FIFO write is visible to the FSM 1 cycle after acceptance: write at cycle W in IDLE with run=1 → LOAD at W+1.
- Simultaneous write and pop: fifo_level unchanged; the full condition is evaluated before the pop, so ready stays 0 when full.
- Simultaneous flush and write: ready=0, so the write is dropped. flush has priority over run and over note_done.
- fifo_level updates the cycle after a push/pop.

## Test plan
- Reset mid-PLAY → all outputs return to reset values immediately; fifo_level=0; no saw_step until a new note is written.
- Single note period=2, dur=1, run=1 → saw_clear at LOAD; 256 saw_steps spaced 2 cycles apart; note_done on step 256; then IDLE with mute=1, busy=0.
- Notes (3,1), (0 rest,1), (1,2) queued → back-to-back playback:
  - note 1: 256 steps at 3-cycle spacing
  - rest: 256×REST_PER cycles with mute=1 and no steps
  - note 3: 512 steps, one per cycle
  - 3 note_done pulses, one LOAD cycle between notes.
- Write 9 notes with run=0 → first 8 accepted, note_ready=0 on the 9th, fifo_level=8. Raise run → one pop, and ready returns.
- run dropped for 10 cycles mid-note (period=4) → no steps during the pause; step spacing resumes exactly where it left off; total step count is still 256.
- flush during step 100 with 3 notes queued → next cycle: IDLE, fifo_level=0, saw_clear=1, mute=1, no note_done; a concurrent write is rejected.

Source files
------------

// File: rtl/saw_note_scheduler.sv
// saw_note_scheduler
//   Note sequencer for the 8-bit sawtooth voice. Queues (period, duration)
//   notes in a small FIFO and plays them back-to-back by generating the
//   sawtooth datapath's per-step enable and synchronous clear, plus mute and
//   status for the output mixer.
//
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   note_valid     host offers a note this cycle
//   note_ready     FIFO can accept (not full, no flush)
//   note_period    clocks per sawtooth step, 0 = rest
//   note_dur       note length in full sawtooth cycles (0 behaves as 1)
//   run            level; 0 pauses playback
//   flush          pulse; empty FIFO and abort the current note
//   saw_step       one-cycle enable: advance sawtooth by one
//   saw_clear      one-cycle: force sawtooth to 0
//   mute           mixer must silence output
//   busy           scheduler not idle
//   note_done      one-cycle pulse at the end of each note/rest
//   fifo_level     FIFO occupancy
module saw_note_scheduler #(
  parameter int DEPTH    = 8,
  parameter int PER_W    = 16,
  parameter int DUR_W    = 8,
  parameter int REST_PER = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       note_valid,
  output logic                       note_ready,
  input  logic [PER_W-1:0]           note_period,
  input  logic [DUR_W-1:0]           note_dur,
  input  logic                       run,
  input  logic                       flush,
  output logic                       saw_step,
  output logic                       saw_clear,
  output logic                       mute,
  output logic                       busy,
  output logic                       note_done,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- FIFO
  logic [PER_W-1:0] per_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic             full, empty, push, pop;

  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign note_ready = !full && !flush;
  assign push       = note_valid && note_ready;
  assign pop        = (state == LOAD) && !flush;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) begin
      per_mem[wr_ptr] <= note_period;
      dur_mem[wr_ptr] <= note_dur;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------- timing
  logic [PER_W-1:0] head_per, per_cnt, per_rld;
  logic [DUR_W-1:0] head_dur, cyc_cnt;
  logic [7:0]       step_cnt;
  logic             rest_q, flush_q;
  logic             tick, wrap, last, avail;

  assign head_per = per_mem[rd_ptr];
  assign head_dur = dur_mem[rd_ptr];

  // A tick is the end of one step period; suppressed when aborting.
  assign tick = (state == PLAY) && run && (per_cnt == '0) && !flush;
  assign wrap = tick && (step_cnt == 8'hFF);
  assign last = wrap && (cyc_cnt == '0);

  // A note being written this cycle is in the FIFO by the next one, so it
  // already counts as available for a LOAD decision.
  assign avail = !empty || push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt  <= '0;
      per_rld  <= '0;
      step_cnt <= '0;
      cyc_cnt  <= '0;
      rest_q   <= 1'b0;
    end else if (state == LOAD) begin
      rest_q   <= (head_per == '0);
      per_rld  <= (head_per == '0) ? PER_W'(REST_PER - 1) : head_per - PER_W'(1);
      per_cnt  <= (head_per == '0) ? PER_W'(REST_PER - 1) : head_per - PER_W'(1);
      step_cnt <= '0;
      cyc_cnt  <= (head_dur == '0) ? '0 : head_dur - DUR_W'(1);
    end else if (state == PLAY && run) begin
      if (per_cnt == '0) begin
        per_cnt  <= per_rld;
        step_cnt <= step_cnt + 8'd1;
        if (wrap && cyc_cnt != '0) cyc_cnt <= cyc_cnt - DUR_W'(1);
      end else begin
        per_cnt <= per_cnt - PER_W'(1);
      end
    end
  end

  // saw_clear is also issued the cycle after a flush so the datapath
  // restarts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flush_q <= 1'b0;
    else       flush_q <= flush;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (run && avail) state_nxt = LOAD;
        LOAD:    state_nxt = PLAY;
        PLAY:    if (last) state_nxt = avail ? LOAD : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    saw_clear = (state == LOAD) || flush_q;
    mute      = !((state == PLAY) && !rest_q);
    saw_step  = tick && !rest_q;
    note_done = last;
  end

endmodule

// File: tb/tb_saw_note_scheduler.sv
// Bench for saw_note_scheduler: directed scenarios plus random traffic, all
// outputs compared every cycle against a note-level reference model.
module tb_saw_note_scheduler;

  localparam int DEPTH    = 8;
  localparam int PER_W    = 16;
  localparam int DUR_W    = 8;
  localparam int REST_PER = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             note_valid, note_ready, run, flush;
  logic [PER_W-1:0] note_period;
  logic [DUR_W-1:0] note_dur;
  logic             saw_step, saw_clear, mute, busy, note_done;
  logic [3:0]       fifo_level;

  saw_note_scheduler #(.DEPTH(DEPTH), .PER_W(PER_W), .DUR_W(DUR_W), .REST_PER(REST_PER)) dut (
    .clk(clk), .reset(reset), .note_valid(note_valid), .note_ready(note_ready),
    .note_period(note_period), .note_dur(note_dur), .run(run), .flush(flush),
    .saw_step(saw_step), .saw_clear(saw_clear), .mute(mute), .busy(busy),
    .note_done(note_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of pending notes; the current note is tracked as
  // "cycles until next step" and "steps left in the note".
  int q_per[$];
  int q_dur[$];
  int mode;          // 0 idle, 1 loading, 2 playing
  bit cur_rest;
  int cur_eff, wait_c, steps_left;
  bit fl_prev;
  int n_steps, n_done;

  task automatic m_reset();
    q_per.delete(); q_dur.delete();
    mode = 0; cur_rest = 0; cur_eff = 0; wait_c = 0; steps_left = 0; fl_prev = 0;
  endtask

  task automatic cyc(input bit v, input int per, input int dur, input bit r, input bit f);
    bit e_ready, e_tick, push;
    @(negedge clk);
    note_valid  = v;
    note_period = PER_W'(per);
    note_dur    = DUR_W'(dur);
    run         = r;
    flush       = f;
    #1;
    e_ready = (q_per.size() < DEPTH) && !f;
    e_tick  = (mode == 2) && r && (wait_c == 1) && !f;
    chk("ready", note_ready, e_ready);
    chk("level", fifo_level, q_per.size());
    chk("busy",  busy, mode != 0);
    chk("clear", saw_clear, (mode == 1) || fl_prev);
    chk("mute",  mute, !((mode == 2) && !cur_rest));
    chk("step",  saw_step, e_tick && !cur_rest);
    chk("done",  note_done, e_tick && (steps_left == 1));
    if (saw_step)  n_steps++;
    if (note_done) n_done++;
    push = v && e_ready;
    if (f) begin
      q_per.delete(); q_dur.delete();
      mode = 0;
    end else begin
      case (mode)
        0: if (r && (q_per.size() > 0 || push)) mode = 1;
        1: begin
          int p, d;
          p = q_per.pop_front();
          d = q_dur.pop_front();
          cur_rest   = (p == 0);
          cur_eff    = cur_rest ? REST_PER : p;
          wait_c     = cur_eff;
          steps_left = 256 * ((d == 0) ? 1 : d);
          mode       = 2;
        end
        default: if (r) begin
          if (wait_c == 1) begin
            wait_c = cur_eff;
            steps_left--;
            if (steps_left == 0) mode = (q_per.size() > 0 || push) ? 1 : 0;
          end else begin
            wait_c--;
          end
        end
      endcase
    end
    if (push) begin
      q_per.push_back(per);
      q_dur.push_back(dur);
    end
    fl_prev = f;
  endtask

  task automatic idle_run(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, r, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_step"},  saw_step, 0);
    chk({tag, "_clear"}, saw_clear, 0);
    chk({tag, "_mute"},  mute, 1);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  note_done, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_ready"}, note_ready, 1);
  endtask

  initial begin
    reset = 1; note_valid = 0; note_period = '0; note_dur = '0; run = 0; flush = 0;
    m_reset(); n_steps = 0; n_done = 0;
    #1;
    chk_reset_vals("rst");
    repeat (2) @(negedge clk);
    reset = 0;

    // Single note period 2, dur 1.
    n_steps = 0; n_done = 0;
    cyc(1, 2, 1, 1, 0);
    idle_run(530, 1);
    chk("single_steps", n_steps, 256);
    chk("single_done", n_done, 1);

    // Back-to-back: (3,1), rest, (1,2).
    cyc(1, 3, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 2, 0, 0);
    n_steps = 0; n_done = 0;
    idle_run(768 + 256 * REST_PER + 512 + 20, 1);
    chk("bb_steps", n_steps, 768);
    chk("bb_done", n_done, 3);

    // Fill the FIFO with run low; the ninth offer is refused.
    for (int i = 0; i < 9; i++) cyc(1, 1 + i % 3, 0, 0, 0);
    chk("full_level", fifo_level, 8);
    for (int i = 0; i < 3; i++) cyc(1, 2, 1, 1, 0);
    idle_run(5, 1);
    cyc(0, 0, 0, 0, 1);
    idle_run(3, 0);

    // Pause mid-note, period 4.
    n_steps = 0;
    cyc(1, 4, 1, 1, 0);
    idle_run(200, 1);
    idle_run(10, 0);
    idle_run(1100, 1);
    chk("pause_steps", n_steps, 256);

    // Flush on step 100 of a note with three more queued, with a write.
    for (int i = 0; i < 4; i++) cyc(1, 2, 1, 0, 0);
    n_steps = 0; n_done = 0;
    begin
      int guard = 0;
      while (n_steps < 99 && guard < 1000) begin
        cyc(0, 0, 0, 1, 0);
        guard++;
      end
      chk("flush_timeout", guard < 1000, 1);
    end
    cyc(0, 0, 0, 1, 0);
    cyc(1, 5, 1, 1, 1);
    idle_run(4, 1);
    chk("flush_done", n_done, 0);

    // Reset mid-PLAY.
    cyc(1, 1, 2, 1, 0);
    idle_run(50, 1);
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk_reset_vals("midrst");
    m_reset();
    note_valid = 0; flush = 0; run = 1;
    @(negedge clk);
    reset = 0;
    n_steps = 0;
    idle_run(20, 1);
    chk("midrst_nostep", n_steps, 0);

    // Random traffic.
    for (int i = 0; i < 20000; i++) begin
      cyc(($urandom % 8) == 0, 1 + $urandom % 5, $urandom % 3,
          ($urandom % 16) != 0, ($urandom % 3000) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
